wdomain_rptr_decoder: RTL and testbench

//  Write-clock-domain receiver for the Gray-coded read pointer of the async FIFO.
//  - Synchronizes g_rptr (rclk domain) into wclk and decodes it Gray->binary.
//  - Computes the registered FIFO fill level from the write-side binary pointer.
//  - Generates registered full/almost_full and sticky overflow/protocol-error flags.
//  - Sits beside the write-pointer handler: consumes its b_wptr and w_en; drives the

---
 rtl/wdomain_rptr_decoder.sv | 103 ++++++++++
 tb/tb_wdomain_rptr_decoder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/wdomain_rptr_decoder.sv
// Write-clock-domain receiver for the async FIFO read pointer.
// Synchronizes the Gray read pointer into wclk, decodes it to binary and
// derives the registered fill level, full/almost_full and sticky error flags.
module wdomain_rptr_decoder #(
  parameter int PTR_WIDTH   = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 6
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  input  logic [PTR_WIDTH-1:0] g_rptr,
  input  logic [PTR_WIDTH-1:0] b_wptr,
  input  logic                 w_en,
  input  logic                 clr_err,
  output logic [PTR_WIDTH-1:0] g_rptr_sync,
  output logic [PTR_WIDTH-1:0] b_rptr_sync,
  output logic [PTR_WIDTH-1:0] wr_level,
  output logic                 full,
  output logic                 almost_full,
  output logic                 overflow_err,
  output logic                 gray_err
);

  localparam int                   DEPTH   = 2 ** (PTR_WIDTH - 1);
  localparam logic [PTR_WIDTH-1:0] DEPTH_V = PTR_WIDTH'(DEPTH);
  localparam logic [PTR_WIDTH-1:0] AF_V    = PTR_WIDTH'(AF_THRESH);

  logic [PTR_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [PTR_WIDTH-1:0] g_sync;
  logic [PTR_WIDTH-1:0] prev_q;
  logic [PTR_WIDTH-1:0] b_dec_d, b_rptr_q;
  logic [PTR_WIDTH-1:0] raw_level, level_d, level_q;
  logic [PTR_WIDTH-1:0] g_diff;
  logic                 level_over, gray_jump;
  logic                 full_d, full_q, af_d, af_q;
  logic                 oflow_d, oflow_q, gerr_d, gerr_q;

  assign g_sync = sync_q[SYNC_STAGES-1];

  // Plain flop chain bringing the asynchronous Gray pointer into wclk
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= g_rptr;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    b_dec_d = '0;
    for (int unsigned i = 0; i < PTR_WIDTH; i++) b_dec_d[i] = ^(g_sync >> i);
  end

  // Level, flag and sticky-error next-state; a level above DEPTH is treated
  // as a corrupted pointer: saturate, report full and flag a Gray error
  always_comb begin
    raw_level  = b_wptr - b_rptr_q;
    level_over = raw_level > DEPTH_V;
    level_d    = level_over ? DEPTH_V : raw_level;
    full_d     = (level_d == DEPTH_V);
    af_d       = (level_d >= AF_V);
    g_diff     = g_sync ^ prev_q;
    gray_jump  = |(g_diff & (g_diff - PTR_WIDTH'(1)));
    oflow_d    = oflow_q;
    if (w_en && full_q)  oflow_d = 1'b1;
    else if (clr_err)    oflow_d = 1'b0;
    gerr_d     = gerr_q;
    if (gray_jump || level_over) gerr_d = 1'b1;
    else if (clr_err)            gerr_d = 1'b0;
  end

  // Status registers, all cleared by the asynchronous reset
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      prev_q   <= '0;
      b_rptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      oflow_q  <= 1'b0;
      gerr_q   <= 1'b0;
    end else begin
      prev_q   <= g_sync;
      b_rptr_q <= b_dec_d;
      level_q  <= level_d;
      full_q   <= full_d;
      af_q     <= af_d;
      oflow_q  <= oflow_d;
      gerr_q   <= gerr_d;
    end
  end

  assign g_rptr_sync  = g_sync;
  assign b_rptr_sync  = b_rptr_q;
  assign wr_level     = level_q;
  assign full         = full_q;
  assign almost_full  = af_q;
  assign overflow_err = oflow_q;
  assign gray_err     = gerr_q;

endmodule

// File: tb/tb_wdomain_rptr_decoder.sv
// Directed, table-driven bench for wdomain_rptr_decoder.
module tb_wdomain_rptr_decoder;

  localparam int PW   = 4;
  localparam int SYNC = 2;
  localparam int AF   = 6;

  logic          wclk = 1'b0;
  logic          wrst_n;
  logic [PW-1:0] g_rptr, b_wptr;
  logic          w_en, clr_err;
  logic [PW-1:0] g_rptr_sync, b_rptr_sync, wr_level;
  logic          full, almost_full, overflow_err, gray_err;

  int total = 0;
  int bad   = 0;

  wdomain_rptr_decoder #(
    .PTR_WIDTH  (PW),
    .SYNC_STAGES(SYNC),
    .AF_THRESH  (AF)
  ) dut (
    .wclk        (wclk),
    .wrst_n      (wrst_n),
    .g_rptr      (g_rptr),
    .b_wptr      (b_wptr),
    .w_en        (w_en),
    .clr_err     (clr_err),
    .g_rptr_sync (g_rptr_sync),
    .b_rptr_sync (b_rptr_sync),
    .wr_level    (wr_level),
    .full        (full),
    .almost_full (almost_full),
    .overflow_err(overflow_err),
    .gray_err    (gray_err)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic [PW-1:0] b_wptr;
    logic [PW-1:0] g_rptr;
    logic [PW-1:0] exp_b;
    logic [PW-1:0] exp_level;
    logic          exp_full;
    logic          exp_af;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // advance n active edges, then settle 1 time unit past the last edge
  task automatic step(input int n);
    repeat (n) @(posedge wclk);
    #1;
  endtask

  task automatic clear_errs();
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
  endtask

  function automatic logic [14:0] all_outs();
    return {g_rptr_sync, b_rptr_sync, wr_level, full, almost_full, overflow_err, gray_err};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // b_wptr, g_rptr(Gray), binary rptr, level, full, almost_full
    vecs[0]  = '{4'd0,  4'b0000, 4'd0,  4'd0, 1'b0, 1'b0};
    vecs[1]  = '{4'd5,  4'b0000, 4'd0,  4'd5, 1'b0, 1'b0};
    vecs[2]  = '{4'd6,  4'b0000, 4'd0,  4'd6, 1'b0, 1'b1};
    vecs[3]  = '{4'd8,  4'b0000, 4'd0,  4'd8, 1'b1, 1'b1};
    vecs[4]  = '{4'd1,  4'b1101, 4'd9,  4'd8, 1'b1, 1'b1};
    vecs[5]  = '{4'd12, 4'b0100, 4'd7,  4'd5, 1'b0, 1'b0};
    vecs[6]  = '{4'd3,  4'b0010, 4'd3,  4'd0, 1'b0, 1'b0};
    vecs[7]  = '{4'd2,  4'b1000, 4'd15, 4'd3, 1'b0, 1'b0};
    vecs[8]  = '{4'd10, 4'b0000, 4'd0,  4'd8, 1'b1, 1'b1};
    vecs[9]  = '{4'd15, 4'b1111, 4'd10, 4'd5, 1'b0, 1'b0};
    vecs[10] = '{4'd0,  4'b1111, 4'd10, 4'd6, 1'b0, 1'b1};

    wrst_n = 1'b0; g_rptr = '0; b_wptr = '0; w_en = 1'b0; clr_err = 1'b0;
    #1;
    chk("reset_outputs", 32'(all_outs()), 32'd0);
    step(2);
    @(negedge wclk) wrst_n = 1'b1;
    step(3);
    chk("post_reset_level", 32'(wr_level), 32'd0);

    // steady-state table
    for (int i = 0; i < 11; i++) begin
      b_wptr = vecs[i].b_wptr;
      g_rptr = vecs[i].g_rptr;
      step(SYNC + 3);
      chk($sformatf("v%0d_gsync", i), 32'(g_rptr_sync), 32'(vecs[i].g_rptr));
      chk($sformatf("v%0d_brptr", i), 32'(b_rptr_sync), 32'(vecs[i].exp_b));
      chk($sformatf("v%0d_level", i), 32'(wr_level),    32'(vecs[i].exp_level));
      chk($sformatf("v%0d_full", i),  32'(full),        32'(vecs[i].exp_full));
      chk($sformatf("v%0d_af", i),    32'(almost_full), 32'(vecs[i].exp_af));
    end
    chk("illegal_level_gray_err", 32'(gray_err), 32'd1);

    // latency: rptr 0 -> 1 with b_wptr=3
    b_wptr = 4'd3; g_rptr = 4'b0000;
    step(SYNC + 3);
    clear_errs();
    chk("lat_start_level", 32'(wr_level), 32'd3);
    g_rptr = 4'b0001;
    for (int k = 1; k <= SYNC + 2; k++) begin
      step(1);
      chk($sformatf("lat_gsync_e%0d", k), 32'(g_rptr_sync), (k >= SYNC) ? 32'd1 : 32'd0);
      chk($sformatf("lat_level_e%0d", k), 32'(wr_level), (k == SYNC + 2) ? 32'd2 : 32'd3);
    end
    b_wptr = 4'd8;
    step(1);
    chk("wptr_one_edge_level", 32'(wr_level), 32'd7);
    chk("wptr_one_edge_af", 32'(almost_full), 32'd1);

    // full via wrap, overflow sticky behaviour
    b_wptr = 4'b0001; g_rptr = 4'b1101;
    step(SYNC + 3);
    clear_errs();
    chk("wrap_full", 32'({full, almost_full, wr_level}), 32'({1'b1, 1'b1, 4'd8}));
    chk("no_overflow_yet", 32'(overflow_err), 32'd0);
    w_en = 1'b1;
    step(1);
    w_en = 1'b0;
    chk("overflow_set", 32'(overflow_err), 32'd1);
    step(3);
    chk("overflow_sticky", 32'(overflow_err), 32'd1);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    chk("overflow_cleared", 32'(overflow_err), 32'd0);
    w_en = 1'b1; clr_err = 1'b1;
    step(1);
    w_en = 1'b0; clr_err = 1'b0;
    chk("overflow_set_wins", 32'(overflow_err), 32'd1);
    clear_errs();
    chk("overflow_cleared2", 32'(overflow_err), 32'd0);

    // almost_full / full stepping
    b_wptr = 4'd0; g_rptr = 4'b0000;
    step(SYNC + 3);
    for (int k = 0; k <= 8; k++) begin
      b_wptr = 4'(k);
      step(1);
      chk($sformatf("step%0d_level", k), 32'(wr_level), 32'(k));
      chk($sformatf("step%0d_af", k), 32'(almost_full), (k >= AF) ? 32'd1 : 32'd0);
      chk($sformatf("step%0d_full", k), 32'(full), (k == 8) ? 32'd1 : 32'd0);
    end

    // legal single-bit walks never raise gray_err
    b_wptr = 4'd0; g_rptr = 4'b0000;
    step(SYNC + 3);
    clear_errs();
    chk("gray_clear_start", 32'(gray_err), 32'd0);
    for (int n = 1; n <= 16; n++) begin
      logic [PW-1:0] nb;
      nb = 4'(n);
      b_wptr = nb;
      g_rptr = nb ^ (nb >> 1);
      step(2);
    end
    step(SYNC + 3);
    chk("gray_legal_walk", 32'(gray_err), 32'd0);

    // two-bit jump 0000 -> 0011
    b_wptr = 4'd2; g_rptr = 4'b0011;
    step(SYNC);
    chk("gray_jump_at_sync", 32'({g_rptr_sync, gray_err}), 32'({4'b0011, 1'b0}));
    step(1);
    chk("gray_jump_set", 32'(gray_err), 32'd1);
    step(2);
    chk("gray_sticky", 32'(gray_err), 32'd1);
    clear_errs();
    chk("gray_cleared", 32'(gray_err), 32'd0);

    // reset mid-operation with level 5 and a sample in flight
    b_wptr = 4'd5; g_rptr = 4'b0000;
    step(SYNC + 3);
    clear_errs();
    chk("pre_reset_level", 32'(wr_level), 32'd5);
    g_rptr = 4'b0011;
    step(1);
    wrst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", 32'(all_outs()), 32'd0);
    g_rptr = 4'b0000; b_wptr = 4'd0;
    step(2);
    @(negedge wclk) wrst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      chk($sformatf("post_reset_e%0d", k), 32'({g_rptr_sync, wr_level, gray_err}), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
